// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_pkg
// Description : Shared constants and types for the text-line video path:
//               character ROM geometry, BCD sentinel, per-field mode bit
//               positions and the line-renderer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    // Character ROM geometry: address is {digit, row}.
    localparam int CHAR_ROWS   = 16;
    localparam int CHAR_ADDR_W = 8;

    // All-nines value used as a "no data" marker on BCD fields.
    localparam logic [3:0] BCD_SENTINEL = 4'h9;

    // Bit positions inside a 3-bit field mode word.
    localparam int FM_BLANK_MAX   = 0;
    localparam int FM_BLANK_ZERO  = 1;
    localparam int FM_LZ_SUPPRESS = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_ISSUE = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } render_state_t;

endpackage : video_pkg
`default_nettype wire

// File: rtl/bcd_field_eval.sv
`default_nettype none
// ============================================================================
// Module      : bcd_field_eval
// Description : Combinational evaluation of one multi-digit BCD field.
//               Decides whether the whole field is blanked (all-nines or
//               all-zero tests) and which digits are leading zeros that
//               must render as an empty glyph.
// Ports       : i_bcd      - DIGITS packed nibbles, digit 0 least significant
//               i_mode     - field mode bits (see video_pkg FM_* constants)
//               o_blank    - field is not drawn at all
//               o_suppress - per-digit "draw 8'h00 instead of the glyph"
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_field_eval
    import video_pkg::*;
#(
    parameter int DIGITS = 5
) (
    input  logic [DIGITS*4-1:0] i_bcd,
    input  logic [2:0]          i_mode,
    output logic                o_blank,
    output logic [DIGITS-1:0]   o_suppress
);

    logic w_all_max;
    logic w_all_zero;
    logic w_zero_above;

    always_comb begin
        w_all_max    = 1'b1;
        w_all_zero   = 1'b1;
        w_zero_above = 1'b1;
        o_suppress   = '0;

        // Non-BCD nibbles (>9) fail both tests naturally.
        for (int d = 0; d < DIGITS; d++) begin
            if (i_bcd[d*4 +: 4] != BCD_SENTINEL) w_all_max  = 1'b0;
            if (i_bcd[d*4 +: 4] != 4'h0)         w_all_zero = 1'b0;
        end

        // Walk down from the most significant digit; a digit is a leading
        // zero while it and everything above it is zero. Digit 0 always
        // shows, so a zero value still renders a single "0".
        for (int d = DIGITS - 1; d >= 1; d--) begin
            w_zero_above  = w_zero_above & (i_bcd[d*4 +: 4] == 4'h0);
            o_suppress[d] = i_mode[FM_LZ_SUPPRESS] & w_zero_above;
        end

        o_blank = (i_mode[FM_BLANK_MAX]  & w_all_max) |
                  (i_mode[FM_BLANK_ZERO] & w_all_zero);
    end

endmodule : bcd_field_eval
`default_nettype wire

// File: rtl/bcd_line_renderer.sv
`default_nettype none
// ============================================================================
// Module      : bcd_line_renderer
// Description : Overlays NUM_FIELDS BCD fields onto a pre-rendered text line,
//               one glyph row per render. Copies the base line, walks the
//               fields, issues one character-ROM fetch per shown digit and
//               writes the returned glyph row into the digit's byte slot.
// Ports       : i_clock/i_reset_n - pixel clock, async active-low reset
//               i_start           - render request (restarts at any time)
//               i_row             - glyph row to render
//               i_base_line       - static bitmap for this row
//               i_bcd/i_digit_pos/i_field_mode - field values, slots, modes
//               o_char_addr/i_char_data - external character ROM port
//               o_line_out        - rendered line
//               o_busy/o_done     - render status
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_line_renderer
    import video_pkg::*;
#(
    parameter int NUM_FIELDS  = 4,
    parameter int DIGITS      = 5,
    parameter int LINE_SIZE   = 368,
    parameter int POS_W       = 6,
    parameter int ROM_LATENCY = 3
) (
    input  logic                               i_clock,
    input  logic                               i_reset_n,
    input  logic                               i_start,
    input  logic [3:0]                         i_row,
    input  logic [LINE_SIZE-1:0]               i_base_line,
    input  logic [NUM_FIELDS*DIGITS*4-1:0]     i_bcd,
    input  logic [NUM_FIELDS*DIGITS*POS_W-1:0] i_digit_pos,
    input  logic [NUM_FIELDS*3-1:0]            i_field_mode,
    output logic [CHAR_ADDR_W-1:0]             o_char_addr,
    input  logic [7:0]                         i_char_data,
    output logic [LINE_SIZE-1:0]               o_line_out,
    output logic                               o_busy,
    output logic                               o_done
);

    localparam int FIELD_W = (NUM_FIELDS > 1)  ? $clog2(NUM_FIELDS)  : 1;
    localparam int DIG_W   = (DIGITS > 1)      ? $clog2(DIGITS)      : 1;
    localparam int DRN_W   = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
    localparam int SLOTS   = LINE_SIZE / 8;

    localparam logic [FIELD_W-1:0] LAST_FIELD = FIELD_W'(NUM_FIELDS - 1);
    localparam logic [DIG_W-1:0]   LAST_DIGIT = DIG_W'(DIGITS - 1);
    localparam logic [DRN_W-1:0]   LAST_DRAIN = DRN_W'(ROM_LATENCY - 1);

    // ------------------------------------------------------------------
    // Request snapshot, taken on every start
    // ------------------------------------------------------------------
    logic [3:0]                         r_row;
    logic [NUM_FIELDS*DIGITS*4-1:0]     r_bcd;
    logic [NUM_FIELDS*DIGITS*POS_W-1:0] r_pos;
    logic [NUM_FIELDS*3-1:0]            r_mode;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    render_state_t      r_state;
    render_state_t      w_state_nxt;
    logic [FIELD_W-1:0] r_field;
    logic [FIELD_W-1:0] w_field_nxt;
    logic [DIG_W-1:0]   r_digit;
    logic [DIG_W-1:0]   w_digit_nxt;
    logic [DRN_W-1:0]   r_drain;
    logic [DRN_W-1:0]   w_drain_nxt;
    logic               w_load;
    logic               w_issue;

    logic [CHAR_ADDR_W-1:0] r_char_addr;
    logic [LINE_SIZE-1:0]   r_line;

    // Capture pipeline: one entry per ROM fetch, aligned with the ROM delay.
    logic [ROM_LATENCY-1:0] r_pipe_vld;
    logic [ROM_LATENCY-1:0] r_pipe_blk;
    logic [POS_W-1:0]       r_pipe_pos [ROM_LATENCY];

    // ------------------------------------------------------------------
    // Per-field evaluation
    // ------------------------------------------------------------------
    logic [NUM_FIELDS-1:0] w_blank;
    logic [DIGITS-1:0]     w_suppress [NUM_FIELDS];

    generate
        for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_field
            bcd_field_eval #(
                .DIGITS     (DIGITS)
            ) u_eval (
                .i_bcd      (r_bcd[f*DIGITS*4 +: DIGITS*4]),
                .i_mode     (r_mode[f*3 +: 3]),
                .o_blank    (w_blank[f]),
                .o_suppress (w_suppress[f])
            );
        end
    endgenerate

    // Select the field/digit currently addressed by the sequencer.
    logic             w_cur_blank;
    logic             w_cur_sup;
    logic [3:0]       w_cur_digit;
    logic [POS_W-1:0] w_cur_pos;

    always_comb begin
        w_cur_blank = 1'b0;
        w_cur_sup   = 1'b0;
        w_cur_digit = 4'h0;
        w_cur_pos   = '0;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            if (r_field == FIELD_W'(f)) begin
                w_cur_blank = w_blank[f];
                for (int d = 0; d < DIGITS; d++) begin
                    if (r_digit == DIG_W'(d)) begin
                        w_cur_sup   = w_suppress[f][d];
                        w_cur_digit = r_bcd[(f*DIGITS + d)*4 +: 4];
                        w_cur_pos   = r_pos[(f*DIGITS + d)*POS_W +: POS_W];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic w_last_field;
    assign w_last_field = (r_field == LAST_FIELD);

    always_comb begin
        w_state_nxt = r_state;
        w_field_nxt = r_field;
        w_digit_nxt = r_digit;
        w_drain_nxt = r_drain;
        w_load      = 1'b0;
        w_issue     = 1'b0;

        if (i_start) begin
            // A new request preempts whatever is in flight.
            w_state_nxt = ST_LOAD;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_LOAD: begin
                    w_load      = 1'b1;
                    w_field_nxt = '0;
                    w_state_nxt = ST_CHECK;
                end
                ST_CHECK: begin
                    if (!w_cur_blank) begin
                        w_digit_nxt = '0;
                        w_state_nxt = ST_ISSUE;
                    end else if (w_last_field) begin
                        w_drain_nxt = '0;
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_field_nxt = r_field + 1'b1;
                        w_state_nxt = ST_CHECK;
                    end
                end
                ST_ISSUE: begin
                    w_issue = 1'b1;
                    if (r_digit != LAST_DIGIT) begin
                        w_digit_nxt = r_digit + 1'b1;
                    end else if (w_last_field) begin
                        w_drain_nxt = '0;
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_field_nxt = r_field + 1'b1;
                        w_state_nxt = ST_CHECK;
                    end
                end
                ST_DRAIN: begin
                    // Wait for the last fetch to clear the capture pipeline.
                    if (r_drain == LAST_DRAIN) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_drain_nxt = r_drain + 1'b1;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [POS_W-1:0] w_cap_pos;
    logic [7:0]       w_cap_byte;

    assign w_cap_pos  = r_pipe_pos[ROM_LATENCY-1];
    assign w_cap_byte = r_pipe_blk[ROM_LATENCY-1] ? 8'h00 : i_char_data;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_field     <= '0;
            r_digit     <= '0;
            r_drain     <= '0;
            r_row       <= '0;
            r_bcd       <= '0;
            r_pos       <= '0;
            r_mode      <= '0;
            r_char_addr <= '0;
            r_line      <= '0;
            r_pipe_vld  <= '0;
            r_pipe_blk  <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                r_pipe_pos[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_field <= w_field_nxt;
            r_digit <= w_digit_nxt;
            r_drain <= w_drain_nxt;

            if (i_start) begin
                r_row      <= i_row;
                r_bcd      <= i_bcd;
                r_pos      <= i_digit_pos;
                r_mode     <= i_field_mode;
                // Drop every fetch of the aborted render, including the
                // one that would have been captured on this edge.
                r_pipe_vld <= '0;
            end else begin
                for (int i = ROM_LATENCY - 1; i >= 1; i--) begin
                    r_pipe_vld[i] <= r_pipe_vld[i-1];
                    r_pipe_blk[i] <= r_pipe_blk[i-1];
                    r_pipe_pos[i] <= r_pipe_pos[i-1];
                end
                r_pipe_vld[0] <= w_issue;
                r_pipe_blk[0] <= w_cur_sup;
                r_pipe_pos[0] <= w_cur_pos;

                if (w_issue) begin
                    r_char_addr <= {w_cur_digit, r_row};
                end

                if (w_load) begin
                    r_line <= i_base_line;
                end else if (r_pipe_vld[ROM_LATENCY-1]) begin
                    // Slots that would run past the line write nothing.
                    for (int s = 0; s < SLOTS; s++) begin
                        if (int'(w_cap_pos) == s) begin
                            r_line[s*8 +: 8] <= w_cap_byte;
                        end
                    end
                end
            end
        end
    end

    assign o_char_addr = r_char_addr;
    assign o_line_out  = r_line;
    assign o_busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign o_done      = (r_state == ST_DONE);

endmodule : bcd_line_renderer
`default_nettype wire

// File: doc/bcd_line_renderer.md
# bcd_line_renderer

Parametrised renderer that overlays N multi-digit BCD fields onto a pre-rendered text-line bitmap, one glyph row at a time. It sits between the per-line text memories and the pixel serialiser in the video path. Once per line it copies the static base line, fetches digit glyphs from the shared character ROM and writes each glyph row into configurable byte slots. Per field it can blank on an all-nines sentinel, blank on zero, and suppress leading zeros.

## Interface
- NUM_FIELDS, 4: number of BCD fields.
- DIGITS, 5: digits per field; digit 0 is the least significant, at `bcd[f*DIGITS*4 +: 4]`.
- LINE_SIZE, 368: line bitmap width in bits; must be a multiple of 8.
- POS_W, 6: width of one glyph byte-slot index.
- ROM_LATENCY, 3: cycles from a `char_addr` update until the matching `char_data` is captured.

- clock  in  1  video pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle render request; sampled every cycle.
- row  in  4  glyph row, 0..15.
- base_line  in  LINE_SIZE  static text bitmap for this row.
- bcd  in  NUM_FIELDS*DIGITS*4  packed BCD values.
- digit_pos  in  NUM_FIELDS*DIGITS*POS_W  byte slot per digit. Glyph goes to `line_out[pos*8 +: 8]`.
- field_mode  in  NUM_FIELDS*3  per field: bit0 blank-if-all-9s, bit1 blank-if-zero, bit2 suppress leading zeros.
- char_addr  out  8  ROM address `{digit, row}`, i.e. `row + (digit << 4)`.
- char_data  in  8  ROM glyph row.
- line_out  out  LINE_SIZE  rendered line.
- busy  out  1  high from the cycle after `start` until `done`.
- done  out  1  one-cycle pulse when `line_out` is final.

## Operation
- Reset: `line_out`, `char_addr`, `busy`, `done` and all internal state are 0; FSM enters IDLE.
- `start` in any state, including mid-render, restarts the render. It latches `row`, `bcd`, `digit_pos` and `field_mode`, and flushes the capture pipeline. Pending writes from the aborted render are discarded.
- States:
  - IDLE → LOAD on `start`.
  - LOAD: `line_out <= base_line`; field index f = 0; → CHECK.
  - CHECK (1 cycle): evaluate field f.
    - blank if (bit0 and every digit == 9) or (bit1 and every digit == 0).
    - blank → next field's CHECK, or DRAIN after the last field.
    - otherwise → ISSUE.
  - ISSUE (DIGITS cycles, digit d = 0..DIGITS-1): drive `char_addr` and push `{pos, blank_glyph}` into a ROM_LATENCY-deep capture pipeline. After the last digit → next CHECK or DRAIN.
  - DRAIN (ROM_LATENCY cycles) → DONE.
  - DONE: `done = 1` for one cycle → IDLE.
- Leading-zero suppression (bit2): digits above the highest nonzero digit get `blank_glyph = 1` and write 8'h00 instead of ROM data. Digit 0 is never suppressed. Suppressed digits still occupy an issue slot, so timing is independent of value.
- Blanked fields leave the `base_line` bytes untouched.
- Capture: when a pipeline entry emerges, write `line_out[pos*8 +: 8]` with `char_data`, or 8'h00 if `blank_glyph`. Captures overlap later CHECK/ISSUE cycles.
- Slot collisions: later digits/fields overwrite earlier ones. `pos*8+7 >= LINE_SIZE` writes nothing.
- Non-BCD nibbles (>9) are fetched unchanged. They never match the sentinel or zero tests.

## Timing
- Render latency: `done` is high exactly `1 + Σf(1 + shown_f*DIGITS) + ROM_LATENCY` cycles after the edge that samples `start`.
- Defaults, all fields shown: 1 + 4*6 + 3 = 28 cycles.
- `line_out` is only guaranteed final while `done` is high and until the next `start`. Intermediate values are visible.
- `char_addr` holds its last value outside ISSUE.

## Structure
- Shared package `video_pkg`:
  - `CHAR_ROWS = 16`.
  - `CHAR_ADDR_W = 8`.
  - `BCD_SENTINEL` digit value 4'h9.
  - field mode bit constants `FM_BLANK_MAX`, `FM_BLANK_ZERO`, `FM_LZ_SUPPRESS`.
  - FSM state enum.
- One natural sub-module: `bcd_field_eval`. It is combinational and, for one field, outputs `blank` plus a DIGITS-wide `suppress` vector.
- The character ROM stays external so it can be shared with the resolution line.

## Test plan
- Reset mid-ISSUE (`reset_n` low for 1 cycle) → `line_out = 0`, `busy = 0`, no `done`; the next `start` renders normally.
- Defaults, all modes 0, field 0 = 12345, row = 3:
  - `char_addr` sequence 0x53, 0x43, 0x33, 0x23, 0x13 in consecutive cycles.
  - `done` at cycle 28.
  - ROM data lands at the programmed slots.
- Field 1 = 99999 with mode 3'b001 → field 1 skipped, its bytes equal `base_line`, `done` at cycle 23.
- Field 2 = 00042 with mode 3'b100 → digits 2–4 write 8'h00, digits 0–1 show ROM glyphs, `done` still at cycle 28.
- Field 3 = 00000 with mode 3'b110 → blanked (zero test wins over suppression), `done` at cycle 23.
- Second `start` 10 cycles into a render, with `bcd` changed → no writes from the first request. `done` arrives 28 cycles after the second `start` with the new values.
